// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//
// MEM pipeline stage that sits directly behind the EX/MEM register.
//   - Resolves branches combinationally (PCSrc, branchTarget).
//   - Performs loads and stores against an external data memory through a
//     variable-latency req/ack handshake. An access that never completes is
//     aborted after TIMEOUT cycles.
//   - Freezes the upstream pipeline (stall) while an access is outstanding.
//   - Owns the MEM/WB pipeline register that drives writeback.
//
// Ports
//   clock, resetN            rising-edge clock, asynchronous active-low reset
//   brachAdr, zero, Branch   branch inputs from EX/MEM
//   ALUres, RegValue         ALU result / byte address and store data
//   writeReg                 destination register
//   MemRead, MemWrite        memory op request (both set = write)
//   RegWrite, MemtoReg       writeback control
//   PCSrc, branchTarget      branch decision and target to IF
//   stall                    freeze PC, IF/ID, ID/EX, EX/MEM
//   memReq, memWe, memAddr,  memory request side, held stable while an
//   memWdata                 access is outstanding
//   memRdata, memAck         memory response (memAck is a one-cycle pulse)
//   readDataOut, ALUresOut,  MEM/WB register outputs
//   writeRegOut, RegWriteOut,
//   MemtoRegOut
//   memError                 sticky misaligned-access / timeout flag
// ---------------------------------------------------------------------------
module mem_access_stage #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic [31:0]       brachAdr,
    input  logic              zero,
    input  logic [DATA_W-1:0] ALUres,
    input  logic [DATA_W-1:0] RegValue,
    input  logic [4:0]        writeReg,
    input  logic              Branch,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    output logic              PCSrc,
    output logic [31:0]       branchTarget,
    output logic              stall,
    output logic              memReq,
    output logic              memWe,
    output logic [DATA_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic [DATA_W-1:0] memRdata,
    input  logic              memAck,
    output logic [DATA_W-1:0] readDataOut,
    output logic [DATA_W-1:0] ALUresOut,
    output logic [4:0]        writeRegOut,
    output logic              RegWriteOut,
    output logic              MemtoRegOut,
    output logic              memError
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              memReq_q, memReq_d;
    logic              memWe_q, memWe_d;
    logic [DATA_W-1:0] memAddr_q, memAddr_d;
    logic [DATA_W-1:0] memWdata_q, memWdata_d;
    logic [DATA_W-1:0] readData_q, readData_d;
    logic [DATA_W-1:0] aluRes_q, aluRes_d;
    logic [4:0]        writeReg_q, writeReg_d;
    logic              regWrite_q, regWrite_d;
    logic              memtoReg_q, memtoReg_d;
    logic              memError_q, memError_d;

    logic accessReq;
    logic aligned;
    logic lastWait;
    logic stallCore;

    assign accessReq = MemRead | MemWrite;
    assign aligned   = (ALUres[1:0] == 2'b00);
    assign lastWait  = (cnt_q == LAST_WAIT);

    assign PCSrc        = Branch & zero;
    assign branchTarget = brachAdr;

    // Nothing can be in flight while reset is held, so the upstream pipeline
    // is never frozen during reset even if EX/MEM still shows a memory op.
    assign stall = resetN & stallCore;

    assign memReq      = memReq_q;
    assign memWe       = memWe_q;
    assign memAddr     = memAddr_q;
    assign memWdata    = memWdata_q;
    assign readDataOut = readData_q;
    assign ALUresOut   = aluRes_q;
    assign writeRegOut = writeReg_q;
    assign RegWriteOut = regWrite_q;
    assign MemtoRegOut = memtoReg_q;
    assign memError    = memError_q;

    // Next-state and stall logic. A "bubble" only clears the writeback
    // controls; the MEM/WB data fields are harmless when RegWriteOut is 0.
    // The request-side registers are only rewritten when a new access starts,
    // which keeps them stable for the whole ACCESS phase.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        memReq_d   = memReq_q;
        memWe_d    = memWe_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        readData_d = readData_q;
        aluRes_d   = aluRes_q;
        writeReg_d = writeReg_q;
        regWrite_d = regWrite_q;
        memtoReg_d = memtoReg_q;
        memError_d = memError_q;
        stallCore  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!accessReq) begin
                    aluRes_d   = ALUres;
                    writeReg_d = writeReg;
                    regWrite_d = RegWrite;
                    memtoReg_d = MemtoReg;
                    readData_d = '0;
                end else if (!aligned) begin
                    memError_d = 1'b1;
                    regWrite_d = 1'b0;
                    memtoReg_d = 1'b0;
                end else begin
                    stallCore  = 1'b1;
                    memAddr_d  = ALUres;
                    memWdata_d = RegValue;
                    memWe_d    = MemWrite;
                    memReq_d   = 1'b1;
                    cnt_d      = '0;
                    regWrite_d = 1'b0;
                    memtoReg_d = 1'b0;
                    state_d    = ACCESS;
                end
            end

            ACCESS: begin
                if (memAck) begin
                    // Completion cycle: stall drops so EX/MEM advances at the
                    // same edge that writes the result into MEM/WB.
                    readData_d = memWe_q ? '0 : memRdata;
                    aluRes_d   = ALUres;
                    writeReg_d = writeReg;
                    regWrite_d = RegWrite;
                    memtoReg_d = MemtoReg;
                    memReq_d   = 1'b0;
                    state_d    = IDLE;
                end else if (lastWait) begin
                    // Abort: the held instruction is dropped as a bubble.
                    memReq_d   = 1'b0;
                    memError_d = 1'b1;
                    regWrite_d = 1'b0;
                    memtoReg_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    cnt_d      = cnt_q + 1'b1;
                    stallCore  = 1'b1;
                    regWrite_d = 1'b0;
                    memtoReg_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and pipeline registers; reset aborts any access in progress.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            readData_q <= '0;
            aluRes_q   <= '0;
            writeReg_q <= '0;
            regWrite_q <= 1'b0;
            memtoReg_q <= 1'b0;
            memError_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            memReq_q   <= memReq_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            readData_q <= readData_d;
            aluRes_q   <= aluRes_d;
            writeReg_q <= writeReg_d;
            regWrite_q <= regWrite_d;
            memtoReg_q <= memtoReg_d;
            memError_q <= memError_d;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_access_stage
//
// Self-checking bench for mem_access_stage (built with TIMEOUT=4).
// Table-driven vectors for branch / pass-through behaviour, hand-written
// sequences for load, store, misaligned, timeout and reset-mid-access, then
// randomized traffic compared against a cycle-level reference model that
// tracks an outstanding access as "busy + cycles waited".
// ---------------------------------------------------------------------------
module tb_mem_access_stage;

    localparam int TO = 4;

    typedef struct packed {
        logic [31:0] brachAdr;
        logic        zero;
        logic [31:0] ALUres;
        logic [31:0] RegValue;
        logic [4:0]  writeReg;
        logic        Branch;
        logic        MemRead;
        logic        MemWrite;
        logic        RegWrite;
        logic        MemtoReg;
    } exmem_t;

    typedef struct {
        exmem_t      in;
        logic        expPCSrc;
        logic [31:0] expAlu;
        logic [4:0]  expWr;
        logic        expRw;
        logic        expM2r;
    } vec_t;

    logic        clock;
    logic        resetN;
    logic [31:0] brachAdr;
    logic        zero;
    logic [31:0] ALUres;
    logic [31:0] RegValue;
    logic [4:0]  writeReg;
    logic        Branch, MemRead, MemWrite, RegWrite, MemtoReg;
    logic        PCSrc;
    logic [31:0] branchTarget;
    logic        stall;
    logic        memReq, memWe;
    logic [31:0] memAddr, memWdata;
    logic [31:0] memRdata;
    logic        memAck;
    logic [31:0] readDataOut, ALUresOut;
    logic [4:0]  writeRegOut;
    logic        RegWriteOut, MemtoRegOut, memError;

    int nChecks = 0;
    int nFail   = 0;

    // Reference model state
    bit          mBusy;
    int          mWaited;
    logic        mReq, mWe, mRw, mM2r, mErr;
    logic [31:0] mAddr, mWdata, mRd, mAlu;
    logic [4:0]  mWr;

    mem_access_stage #(
        .DATA_W (32),
        .TIMEOUT(TO),
        .CNT_W  (3)
    ) dut (
        .clock       (clock),
        .resetN      (resetN),
        .brachAdr    (brachAdr),
        .zero        (zero),
        .ALUres      (ALUres),
        .RegValue    (RegValue),
        .writeReg    (writeReg),
        .Branch      (Branch),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .RegWrite    (RegWrite),
        .MemtoReg    (MemtoReg),
        .PCSrc       (PCSrc),
        .branchTarget(branchTarget),
        .stall       (stall),
        .memReq      (memReq),
        .memWe       (memWe),
        .memAddr     (memAddr),
        .memWdata    (memWdata),
        .memRdata    (memRdata),
        .memAck      (memAck),
        .readDataOut (readDataOut),
        .ALUresOut   (ALUresOut),
        .writeRegOut (writeRegOut),
        .RegWriteOut (RegWriteOut),
        .MemtoRegOut (MemtoRegOut),
        .memError    (memError)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive all EX/MEM-side inputs at once.
    task automatic applyStimulus(input exmem_t s);
        brachAdr = s.brachAdr;
        zero     = s.zero;
        ALUres   = s.ALUres;
        RegValue = s.RegValue;
        writeReg = s.writeReg;
        Branch   = s.Branch;
        MemRead  = s.MemRead;
        MemWrite = s.MemWrite;
        RegWrite = s.RegWrite;
        MemtoReg = s.MemtoReg;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " memReq"}, memReq, 0);
        checkOutput({tag, " memWe"}, memWe, 0);
        checkOutput({tag, " memAddr"}, memAddr, 0);
        checkOutput({tag, " memWdata"}, memWdata, 0);
        checkOutput({tag, " readDataOut"}, readDataOut, 0);
        checkOutput({tag, " ALUresOut"}, ALUresOut, 0);
        checkOutput({tag, " writeRegOut"}, writeRegOut, 0);
        checkOutput({tag, " RegWriteOut"}, RegWriteOut, 0);
        checkOutput({tag, " MemtoRegOut"}, MemtoRegOut, 0);
        checkOutput({tag, " memError"}, memError, 0);
    endtask

    // Assert reset away from the clock edge, release it on a falling edge,
    // and let one NOP edge pass so the bench is back at posedge+1.
    task automatic doReset();
        exmem_t nop;
        nop = '0;
        applyStimulus(nop);
        memAck   = 1'b0;
        memRdata = '0;
        resetN   = 1'b0;
        #1;
        @(negedge clock);
        resetN = 1'b1;
        tick();
    endtask

    function automatic void modelReset();
        mBusy   = 0;
        mWaited = 0;
        mReq    = 0;
        mWe     = 0;
        mAddr   = '0;
        mWdata  = '0;
        mRd     = '0;
        mAlu    = '0;
        mWr     = '0;
        mRw     = 0;
        mM2r    = 0;
        mErr    = 0;
    endfunction

    function automatic logic modelStall();
        logic wants;
        wants = MemRead || MemWrite;
        if (!mBusy)
            return wants && (ALUres % 4 == 0);
        return !memAck && (mWaited + 1 < TO);
    endfunction

    // What the stage should do at one rising edge, given the inputs
    // presented during the cycle that just ended.
    function automatic void modelEdge();
        logic wants;
        wants = MemRead || MemWrite;
        if (!mBusy) begin
            if (!wants) begin
                mAlu = ALUres; mWr = writeReg; mRw = RegWrite; mM2r = MemtoReg; mRd = 0;
            end else if (ALUres % 4 != 0) begin
                mErr = 1; mRw = 0; mM2r = 0;
            end else begin
                mBusy = 1; mWaited = 0; mReq = 1;
                mWe = MemWrite; mAddr = ALUres; mWdata = RegValue;
                mRw = 0; mM2r = 0;
            end
        end else if (memAck) begin
            mRd  = mWe ? 32'h0 : memRdata;
            mAlu = ALUres; mWr = writeReg; mRw = RegWrite; mM2r = MemtoReg;
            mReq = 0; mBusy = 0;
        end else begin
            mWaited++;
            mRw = 0; mM2r = 0;
            if (mWaited == TO) begin
                mReq = 0; mBusy = 0; mErr = 1;
            end
        end
    endfunction

    vec_t   vecs[5];
    exmem_t s;
    bit     holdIn;
    logic   expStall;

    initial begin
        // Table: non-memory ops exercising branch resolution and pass-through.
        vecs[0] = '{'{32'h40, 1'b1, 32'h7, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0},
                    1'b1, 32'h7, 5'd3, 1'b1, 1'b0};
        vecs[1] = '{'{32'h40, 1'b0, 32'h100, 32'h0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
                    1'b0, 32'h100, 5'd31, 1'b0, 1'b1};
        vecs[2] = '{'{32'h80, 1'b1, 32'hFFFF_FFFF, 32'h5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
                    1'b0, 32'hFFFF_FFFF, 5'd0, 1'b1, 1'b0};
        vecs[3] = '{'{32'h1234, 1'b1, 32'h13, 32'h0, 5'd17, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1},
                    1'b1, 32'h13, 5'd17, 1'b1, 1'b1};
        vecs[4] = '{'{32'h0, 1'b0, 32'h0, 32'h0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
                    1'b0, 32'h0, 5'd1, 1'b0, 1'b0};

        resetN = 1'b0;
        s = '0;
        applyStimulus(s);
        memAck   = 1'b0;
        memRdata = '0;
        #2;
        checkResetState("reset");
        checkOutput("reset stall", stall, 0);
        doReset();
        checkResetState("post-reset");

        // Pass-through and branch vectors
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].in);
            #1;
            checkOutput($sformatf("vec%0d PCSrc", i), PCSrc, vecs[i].expPCSrc);
            checkOutput($sformatf("vec%0d branchTarget", i), branchTarget, vecs[i].in.brachAdr);
            checkOutput($sformatf("vec%0d stall", i), stall, 0);
            tick();
            checkOutput($sformatf("vec%0d ALUresOut", i), ALUresOut, vecs[i].expAlu);
            checkOutput($sformatf("vec%0d writeRegOut", i), writeRegOut, vecs[i].expWr);
            checkOutput($sformatf("vec%0d RegWriteOut", i), RegWriteOut, vecs[i].expRw);
            checkOutput($sformatf("vec%0d MemtoRegOut", i), MemtoRegOut, vecs[i].expM2r);
            checkOutput($sformatf("vec%0d readDataOut", i), readDataOut, 0);
            checkOutput($sformatf("vec%0d memReq", i), memReq, 0);
        end

        // Load acknowledged in the third request cycle
        s = '0; s.ALUres = 32'h10; s.MemRead = 1; s.RegWrite = 1; s.MemtoReg = 1; s.writeReg = 5'd5;
        applyStimulus(s);
        memAck = 1'b0;
        #1;
        checkOutput("load stall issue", stall, 1);
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput($sformatf("load memReq c%0d", c), memReq, 1);
            checkOutput($sformatf("load memAddr c%0d", c), memAddr, 32'h10);
            checkOutput($sformatf("load memWe c%0d", c), memWe, 0);
            checkOutput($sformatf("load RegWriteOut c%0d", c), RegWriteOut, 0);
            if (c == 2) begin
                memAck   = 1'b1;
                memRdata = 32'hDEAD_BEEF;
            end
            #1;
            checkOutput($sformatf("load stall c%0d", c), stall, (c < 2) ? 1 : 0);
        end
        tick();
        memAck = 1'b0;
        checkOutput("load readDataOut", readDataOut, 32'hDEAD_BEEF);
        checkOutput("load writeRegOut", writeRegOut, 5);
        checkOutput("load RegWriteOut", RegWriteOut, 1);
        checkOutput("load MemtoRegOut", MemtoRegOut, 1);
        checkOutput("load memReq done", memReq, 0);

        // Store acknowledged in the first ACCESS cycle
        s = '0; s.ALUres = 32'h20; s.MemWrite = 1; s.RegValue = 32'h1234_5678;
        applyStimulus(s);
        #1;
        checkOutput("store stall issue", stall, 1);
        tick();
        checkOutput("store memReq", memReq, 1);
        checkOutput("store memWe", memWe, 1);
        checkOutput("store memWdata", memWdata, 32'h1234_5678);
        checkOutput("store memAddr", memAddr, 32'h20);
        memAck   = 1'b1;
        memRdata = 32'hCAFE_F00D;
        #1;
        checkOutput("store stall ack", stall, 0);
        tick();
        memAck = 1'b0;
        checkOutput("store RegWriteOut", RegWriteOut, 0);
        checkOutput("store readDataOut", readDataOut, 0);
        checkOutput("store memReq done", memReq, 0);

        // Misaligned load
        s = '0; s.ALUres = 32'h13; s.MemRead = 1; s.RegWrite = 1;
        applyStimulus(s);
        #1;
        checkOutput("misalign stall", stall, 0);
        tick();
        checkOutput("misalign memReq", memReq, 0);
        checkOutput("misalign memError", memError, 1);
        checkOutput("misalign RegWriteOut", RegWriteOut, 0);

        // Timeout, then reset in the middle of a new access
        doReset();
        checkOutput("timeout pre memError", memError, 0);
        s = '0; s.ALUres = 32'h40; s.MemRead = 1; s.RegWrite = 1;
        applyStimulus(s);
        tick();
        for (int c = 0; c < TO; c++) begin
            checkOutput($sformatf("timeout memReq c%0d", c), memReq, 1);
            checkOutput($sformatf("timeout stall c%0d", c), stall, (c < TO - 1) ? 1 : 0);
            tick();
        end
        checkOutput("timeout memReq end", memReq, 0);
        checkOutput("timeout memError", memError, 1);
        checkOutput("timeout RegWriteOut", RegWriteOut, 0);
        s.ALUres = 32'h44;
        applyStimulus(s);
        tick();
        checkOutput("rst-mid memReq before", memReq, 1);
        resetN = 1'b0;
        #1;
        checkOutput("rst-mid memReq", memReq, 0);
        checkOutput("rst-mid stall", stall, 0);
        checkOutput("rst-mid memError", memError, 0);
        doReset();

        // Randomized traffic against the reference model
        modelReset();
        holdIn = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc % 97 == 96) begin
                doReset();
                modelReset();
                holdIn = 0;
                checkOutput("rand reset memError", memError, 0);
            end
            if (!holdIn) begin
                s.brachAdr = $urandom;
                s.zero     = 1'($urandom_range(0, 1));
                s.ALUres   = $urandom;
                if ($urandom_range(0, 3) != 0) s.ALUres[1:0] = 2'b00;
                s.RegValue = $urandom;
                s.writeReg = 5'($urandom);
                s.Branch   = 1'($urandom_range(0, 1));
                s.MemRead  = ($urandom_range(0, 2) == 0);
                s.MemWrite = ($urandom_range(0, 2) == 0);
                s.RegWrite = 1'($urandom_range(0, 1));
                s.MemtoReg = 1'($urandom_range(0, 1));
                applyStimulus(s);
            end
            memAck   = ($urandom_range(0, 2) == 0);
            memRdata = $urandom;
            #1;
            expStall = modelStall();
            checkOutput("rand stall", stall, expStall);
            checkOutput("rand PCSrc", PCSrc, s.Branch & s.zero);
            holdIn = expStall;
            @(posedge clock);
            modelEdge();
            #1;
            checkOutput("rand memReq", memReq, mReq);
            if (mReq) begin
                checkOutput("rand memAddr", memAddr, mAddr);
                checkOutput("rand memWe", memWe, mWe);
                checkOutput("rand memWdata", memWdata, mWdata);
            end
            checkOutput("rand readDataOut", readDataOut, mRd);
            checkOutput("rand ALUresOut", ALUresOut, mAlu);
            checkOutput("rand writeRegOut", writeRegOut, mWr);
            checkOutput("rand RegWriteOut", RegWriteOut, mRw);
            checkOutput("rand MemtoRegOut", MemtoRegOut, mM2r);
            checkOutput("rand memError", memError, mErr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
MEM pipeline stage fed directly by the EX/MEM register. Resolves branches (PCSrc, target) combinationally. Runs loads/stores against an external data memory with a variable-latency req/ack handshake. Stalls the upstream pipeline while an access is outstanding and holds the MEM/WB pipeline register driving writeback.

Parameters:
DATA_W, 32, datapath and memory word width
TIMEOUT, 16, maximum ACCESS cycles without memAck before the access is aborted
CNT_W, 5, timeout counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
clock  input  1  rising-edge clock
resetN  input  1  asynchronous active-low reset
brachAdr  input  32  branch target from EX/MEM
zero  input  1  ALU zero flag from EX/MEM
ALUres  input  32  ALU result / memory byte address
RegValue  input  32  store data
writeReg  input  5  destination register
Branch, MemRead, MemWrite, RegWrite, MemtoReg  input  1 each  control from EX/MEM
PCSrc  output  1  take-branch to IF
branchTarget  output  32  = brachAdr
stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM
memReq  output  1  memory request
memWe  output  1  1 = write, 0 = read
memAddr  output  32  word-aligned byte address
memWdata  output  32  store data
memRdata  input  32  read data, valid with memAck
memAck  input  1  access complete, one-cycle pulse
readDataOut, ALUresOut  output  32 each  MEM/WB data
writeRegOut  output  5  MEM/WB destination
RegWriteOut, MemtoRegOut  output  1 each  MEM/WB control
memError  output  1  sticky misalign/timeout flag

Behaviour:
- Reset (resetN=0, async): state=IDLE, counter=0. All registered outputs are 0: memReq, memWe, memAddr, memWdata, readDataOut, ALUresOut, writeRegOut, RegWriteOut, MemtoRegOut, memError. Reset mid-access aborts the access with no completion.
- Branch logic (combinational): PCSrc = Branch & zero; branchTarget = brachAdr.
- An access is requested when MemRead|MemWrite. If both are set, the access is a write.
- Aligned means ALUres[1:0]==0.
- FSM IDLE:
  - No access requested: at the edge, MEM/WB loads ALUres, writeReg, RegWrite, MemtoReg; readDataOut=0.
  - Access requested and misaligned: no request issued. memError<=1. MEM/WB gets a bubble (RegWriteOut=0, MemtoRegOut=0). stall=0.
  - Access requested and aligned: stall=1. At the edge, register memAddr=ALUres, memWdata=RegValue, memWe=MemWrite, memReq=1, counter=0; go to ACCESS. MEM/WB gets a bubble.
- FSM ACCESS (EX/MEM contents are held by stall):
  - memAck=1: at the edge, readDataOut<=memRdata (0 for a write), ALUresOut<=ALUres, writeRegOut<=writeReg, RegWriteOut<=RegWrite, MemtoRegOut<=MemtoReg; memReq<=0; go to IDLE. stall=0 in this cycle, so EX/MEM advances at the same edge.
  - memAck=0 and counter==TIMEOUT-1: abort. memReq<=0, memError<=1, MEM/WB bubble, go to IDLE, stall=0.
  - Otherwise: counter++, stall=1, MEM/WB bubble.
- Combinational stall = (IDLE & access & aligned) | (ACCESS & ~memAck & counter!=TIMEOUT-1).
- memAck outside ACCESS is ignored.
- memReq, memAddr, memWe, memWdata are stable throughout ACCESS.
- Minimum memory-op latency is 2 cycles (request cycle plus ack cycle). Non-memory ops take 1 cycle.
- memError clears only on reset.

Test Plan:
1. Load: ALUres=0x10, MemRead=1, RegWrite=1, MemtoReg=1, writeReg=5; memAck with memRdata=0xDEADBEEF in the 3rd memReq cycle -> memReq high 3 cycles, memAddr=0x10, memWe=0, stall high 3 cycles then low; after the completion edge readDataOut=0xDEADBEEF, writeRegOut=5, RegWriteOut=1; RegWriteOut=0 in all earlier stall cycles.
2. Store: MemWrite=1, ALUres=0x20, RegValue=0x12345678, memAck in the first ACCESS cycle -> memWe=1, memWdata=0x12345678, stall exactly 1 cycle, RegWriteOut=0.
3. Pass-through: RegWrite=1, ALUres=7, writeReg=3, no mem op -> next edge ALUresOut=7, writeRegOut=3, RegWriteOut=1; memReq and stall never asserted.
4. Branch: Branch=1, zero=1, brachAdr=0x40 -> PCSrc=1, branchTarget=0x40 in the same cycle; zero=0 -> PCSrc=0.
5. Misaligned: MemRead=1, ALUres=0x13 -> memReq never asserted, memError=1, RegWriteOut=0, stall=0.
6. Timeout/reset: TIMEOUT=4, aligned load, no ack -> memReq high 4 cycles then 0, memError=1, bubble. New aligned access, then resetN low during ACCESS -> memReq=0, stall=0, memError=0 immediately.
